// File: rtl/ex_alu_stage_pkg.sv
// rtl/ex_alu_stage_pkg.sv - shared ALU opcodes, exception causes and state encoding for the execute stage
package ex_alu_stage_pkg;

    // Operation codes exactly as emitted by the ALU control decoder
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_OVF  = 2'b01,
        CAUSE_ILL  = 2'b10
    } exc_cause_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } exc_state_t;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// rtl/ex_alu_stage_alu_core.sv - combinational ALU: result, signed overflow (ADD/SUB only) and illegal-opcode flag
module ex_alu_stage_alu_core
    import ex_alu_stage_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [3:0]       i_ALUOp,
    input  logic [NBITS-1:0] i_A,
    input  logic [NBITS-1:0] i_B,
    output logic [NBITS-1:0] o_Result,
    output logic             o_Overflow,
    output logic             o_Illegal
);

    logic [NBITS-1:0] sum;
    logic [NBITS-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum  = i_A + i_B;
    assign diff = i_A - i_B;

    // Signed overflow: like-signed operands (B inverted for SUB) giving an opposite-signed result
    assign add_ovf = (i_A[NBITS-1] == i_B[NBITS-1]) && (sum[NBITS-1]  != i_A[NBITS-1]);
    assign sub_ovf = (i_A[NBITS-1] != i_B[NBITS-1]) && (diff[NBITS-1] != i_A[NBITS-1]);

    always_comb begin
        o_Result   = '0;
        o_Overflow = 1'b0;
        o_Illegal  = 1'b0;
        case (i_ALUOp)
            OP_AND: o_Result = i_A & i_B;
            OP_OR:  o_Result = i_A | i_B;
            OP_ADD: begin
                o_Result   = sum;
                o_Overflow = add_ovf;
            end
            OP_SUB: begin
                o_Result   = diff;
                o_Overflow = sub_ovf;
            end
            // Correct signed compare even when A-B itself overflows; SLT never traps
            OP_SLT: o_Result = {{(NBITS-1){1'b0}}, diff[NBITS-1] ^ sub_ovf};
            OP_NOR: o_Result = ~(i_A | i_B);
            OP_XOR: o_Result = i_A ^ i_B;
            default: o_Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - registered MIPS execute stage with stall/flush and sticky exception state
module ex_alu_stage
    import ex_alu_stage_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int ALUOP   = 4,
    parameter int REGBITS = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Valid,
    input  logic               i_Stall,
    input  logic               i_Flush,
    input  logic [ALUOP-1:0]   i_ALUOp,
    input  logic               i_TrapEn,
    input  logic [NBITS-1:0]   i_A,
    input  logic [NBITS-1:0]   i_B,
    input  logic [REGBITS-1:0] i_RegDst,
    input  logic               i_RegWrite,
    input  logic               i_ExcAck,
    output logic               o_Valid,
    output logic [NBITS-1:0]   o_Result,
    output logic               o_Zero,
    output logic [REGBITS-1:0] o_RegDst,
    output logic               o_RegWrite,
    output logic               o_ExcPending,
    output logic [1:0]         o_ExcCause
);

    logic [NBITS-1:0] alu_result;
    logic             alu_ovf;
    logic             alu_ill;
    logic             fault_ovf;
    logic             fault_ill;
    logic             fault;
    logic             capture;
    exc_state_t       state;
    exc_state_t       state_next;
    exc_cause_t       cause;

    ex_alu_stage_alu_core #(
        .NBITS (NBITS)
    ) u_alu_core (
        .i_ALUOp    (i_ALUOp),
        .i_A        (i_A),
        .i_B        (i_B),
        .o_Result   (alu_result),
        .o_Overflow (alu_ovf),
        .o_Illegal  (alu_ill)
    );

    assign fault_ovf = i_Valid && i_TrapEn && alu_ovf;
    assign fault_ill = i_Valid && alu_ill;
    assign fault     = fault_ovf || fault_ill;
    assign capture   = !i_Flush && !i_Stall;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // The ack is honoured regardless of stall/flush; only a captured fault arms PEND
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (capture && fault) state_next = ST_PEND;
            ST_PEND: if (i_ExcAck)         state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_Valid    <= 1'b0;
            o_Result   <= '0;
            o_Zero     <= 1'b1;
            o_RegDst   <= '0;
            o_RegWrite <= 1'b0;
            cause      <= CAUSE_NONE;
        end else begin
            if (state == ST_PEND && i_ExcAck) begin
                cause <= CAUSE_NONE;
            end
            if (i_Flush) begin
                o_Valid    <= 1'b0;
                o_RegWrite <= 1'b0;
            end else if (!i_Stall) begin
                o_Result <= alu_result;
                o_Zero   <= (alu_result == '0);
                o_RegDst <= i_RegDst;
                if (state == ST_PEND) begin
                    o_Valid    <= 1'b0;
                    o_RegWrite <= 1'b0;
                end else begin
                    // A faulting instruction stays visible (valid) but never writes back
                    o_Valid    <= i_Valid;
                    o_RegWrite <= i_Valid && i_RegWrite && !fault;
                    if (fault) begin
                        cause <= fault_ill ? CAUSE_ILL : CAUSE_OVF;
                    end
                end
            end
        end
    end

    assign o_ExcPending = (state == ST_PEND);
    assign o_ExcCause   = cause;

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Registered execute stage of the MIPS pipeline. It consumes the 4-bit ALU operation code produced by the ALU control decoder, together with the ID/EX operands, and computes result, zero and overflow. The outcome is registered into the EX/MEM boundary with stall/flush control. It also holds a sticky exception state: on arithmetic overflow or an illegal operation code it squashes following instructions until the control unit acknowledges.

## Interface
- NBITS, 32, datapath width
- ALUOP, 4, width of ALU operation code
- REGBITS, 5, width of destination register index

- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_Valid  input  1  ID/EX slot holds a real instruction
- i_Stall  input  1  downstream not accepting; hold EX/MEM register
- i_Flush  input  1  kill instruction being captured (branch/jump redirect)
- i_ALUOp  input  ALUOP  operation code from ALU control
- i_TrapEn  input  1  overflow traps for this instruction (ADD/SUB/ADDI), 0 for ADDU/SUBU/ADDIU
- i_A, i_B  input  NBITS  operands (rs, rt/immediate)
- i_RegDst  input  REGBITS  destination register index
- i_RegWrite  input  1  instruction writes register file
- i_ExcAck  input  1  control unit acknowledges pending exception
- o_Valid  output  1  EX/MEM slot valid
- o_Result  output  NBITS  registered ALU result
- o_Zero  output  1  registered (o_Result == 0)
- o_RegDst  output  REGBITS  registered destination
- o_RegWrite  output  1  registered, qualified write enable
- o_ExcPending  output  1  sticky exception flag
- o_ExcCause  output  2  00 none, 01 overflow, 10 illegal opcode

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 XOR; all others illegal (decoder emits 1110/1111 for unknown).
- ADD/SUB: NBITS-bit wraparound; overflow = operands' signs (B inverted for SUB) equal and result sign differs.
- SLT: signed; result = {0…, sign(A−B) XOR ovf(A−B)}; never raises overflow.
- Illegal code: result 0.
- Fault = i_Valid & ((i_TrapEn & overflow on ADD/SUB) | illegal).
- Zero computed on the full NBITS result actually registered.
- State machine, two states:
  - RUN: capture normally. On a captured fault (not stalled, not flushed): o_Valid=1, o_RegWrite=0, o_ExcCause set, go to PEND.
  - PEND: o_ExcPending=1; every captured instruction squashed (o_Valid=0, o_RegWrite=0). i_ExcAck returns to RUN at next edge; o_ExcCause cleared to 00.
- i_ExcAck in RUN is ignored.
- Squashed or invalid slot: o_Valid=0, o_RegWrite=0; o_Result/o_RegDst may update (don't-care) but must not be X.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): o_Valid=0, o_Result=0, o_Zero=1, o_RegDst=0, o_RegWrite=0, o_ExcPending=0, o_ExcCause=00, state RUN.
- Latency: one cycle from inputs to all outputs.
- Priority at each edge: reset > flush > stall > capture.
  - Flush: o_Valid=0, o_RegWrite=0 even with i_Stall=1; a faulting instruction being flushed does not enter PEND.
  - Stall: all outputs and state hold; i_ExcAck during stall is still honoured (state only).
- Fault and i_ExcAck on the same edge in PEND: the ack wins (go RUN). The new instruction is squashed because it is captured under PEND.
- Reset mid-PEND returns to RUN with the cause cleared.

## Structure
- Shared package/header: ALU operation-code constants (same values the ALU control decoder emits), exception cause encodings, state encoding.
- One natural combinational sub-module: alu_core (i_ALUOp, i_A, i_B -> result, overflow, illegal). The stage wraps it with registers and the FSM.

## Test plan
- Reset: i_reset=0 mid-run -> all outputs at reset values immediately, o_Zero=1.
- Arithmetic: ADD 0x7FFFFFFF+1 with i_TrapEn=0 -> o_Result=0x80000000, o_RegWrite=1, no exception. Same with i_TrapEn=1 -> o_RegWrite=0, o_ExcCause=01, o_ExcPending=1 next cycle.
- SLT/Zero: SLT A=0x80000000, B=1 -> 1. SUB 5−5 -> o_Result=0, o_Zero=1. NOR 0,0 -> 0xFFFFFFFF.
- Illegal: i_ALUOp=1111, i_Valid=1 -> o_Result=0, cause 10, PEND. The next three instructions give o_Valid=0. i_ExcAck -> RUN, the following ADD 2+3 gives 5.
- Stall/flush: i_Stall=1 for 3 cycles with changing inputs -> outputs frozen. i_Stall=1 and i_Flush=1 together -> o_Valid=0. A flushed overflowing ADD -> no PEND.
- Random ops vs reference model with random stall/flush/ack, checking result, zero, write-enable qualification and state.
